// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
//
// Bank of NUM_CH independent programmable clock dividers. Every channel runs
// entirely on clk: the "divided clock" is delivered as a one-cycle clock-enable
// pulse (tick) plus a registered 50%-duty square wave (div_out). No derived or
// ripple clocks are created.
//
// Each channel holds a counter, an active ratio, a shadow ratio and a pending
// flag. Writes land in the shadow register and are promoted to the active
// register only at a period boundary (wrap), on sync, or immediately while the
// channel is disabled. As a result, a ratio change never produces a shortened
// or stretched period.
//
// Ports
//   clk       in   1        single clock, rising edge
//   rst       in   1        asynchronous active-high reset
//   en        in   NUM_CH   per-channel run enable
//   cfg_wr    in   1        one-cycle config write strobe
//   cfg_ch    in   CH_W     target channel of the write (>= NUM_CH ignored)
//   cfg_div   in   CNT_W    new divide ratio (0 behaves as 1)
//   sync      in   1        phase-align pulse: restarts every channel
//   tick      out  NUM_CH   one-cycle pulse every Deff cycles
//   div_out   out  NUM_CH   square wave with period 2*Deff
//   cfg_pend  out  NUM_CH   shadow ratio waiting to be applied
// -----------------------------------------------------------------------------
module clk_div_bank #(
   parameter int NUM_CH  = 5,
   parameter int CNT_W   = 8,
   parameter int CH_W    = 3,
   parameter int DEF_DIV = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              sync,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_out,
   output logic [NUM_CH-1:0] cfg_pend
);

   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic [CNT_W-1:0] act_reg, act_next;
         logic [CNT_W-1:0] shd_reg, shd_next;
         logic             pend_reg, pend_next;
         logic             tick_reg, tick_next;
         logic             div_reg, div_next;

         logic [CNT_W-1:0] last_cnt;   // Deff - 1, the count value that wraps
         logic             wr_hit;
         logic             wrap;
         logic             apply;

         // Ratio 0 is treated as 1, so the terminal count is 0 in both cases.
         assign last_cnt = (act_reg == '0) ? '0 : (act_reg - ONE);

         // Only a write whose channel index matches exactly hits this channel.
         // Out-of-range indices therefore match no channel and are ignored.
         assign wr_hit = cfg_wr && (cfg_ch == CH_W'(gi));

         // The >= comparison guards against a count that is already past the
         // terminal value; the active ratio only changes while cnt is 0, so
         // in normal operation this is an equality test.
         assign wrap = en[gi] && (cnt_reg >= last_cnt);

         // The shadow ratio is promoted at a period boundary, on sync, or
         // whenever the channel is idle. Promotion always uses the shadow value
         // held before this edge, so a write that coincides with the boundary
         // stays pending for the next one.
         assign apply = pend_reg && (sync || !en[gi] || wrap);

         always_comb begin
            cnt_next  = cnt_reg;
            tick_next = 1'b0;
            div_next  = div_reg;
            act_next  = act_reg;
            shd_next  = shd_reg;
            pend_next = pend_reg;

            // sync wins over the enable and wrap paths.
            if (sync) begin
               cnt_next  = '0;
               tick_next = 1'b0;
               div_next  = 1'b0;
            end else if (!en[gi]) begin
               cnt_next  = '0;
               tick_next = 1'b0;
            end else if (wrap) begin
               cnt_next  = '0;
               tick_next = 1'b1;
               div_next  = ~div_reg;
            end else begin
               cnt_next  = cnt_reg + ONE;
               tick_next = 1'b0;
            end

            if (apply) begin
               act_next  = shd_reg;
               pend_next = 1'b0;
            end

            // A new write always leaves the channel pending, even if an
            // older shadow value is promoted on this same edge.
            if (wr_hit) begin
               shd_next  = cfg_div;
               pend_next = 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg  <= '0;
               act_reg  <= RST_DIV;
               shd_reg  <= RST_DIV;
               pend_reg <= 1'b0;
               tick_reg <= 1'b0;
               div_reg  <= 1'b0;
            end else begin
               cnt_reg  <= cnt_next;
               act_reg  <= act_next;
               shd_reg  <= shd_next;
               pend_reg <= pend_next;
               tick_reg <= tick_next;
               div_reg  <= div_next;
            end
         end

         assign tick[gi]     = tick_reg;
         assign div_out[gi]  = div_reg;
         assign cfg_pend[gi] = pend_reg;
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
//
// Testbench for clk_div_bank. It combines directed scenarios with randomized
// traffic. A behavioural model steps once per rising edge and pushes the
// expected output vectors into a queue. A monitor on the falling edge pops
// each entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

   localparam int NUM_CH  = 5;
   localparam int CNT_W   = 8;
   localparam int CH_W    = 3;
   localparam int DEF_DIV = 2;

   logic              clk     = 1'b0;
   logic              rst     = 1'b1;
   logic [NUM_CH-1:0] en      = '0;
   logic              cfg_wr  = 1'b0;
   logic [CH_W-1:0]   cfg_ch  = '0;
   logic [CNT_W-1:0]  cfg_div = '0;
   logic              sync    = 1'b0;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] div_out;
   logic [NUM_CH-1:0] cfg_pend;

   int checks = 0;
   int errors = 0;
   bit model_stop = 1'b0;

   typedef struct packed {
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] div;
      logic [NUM_CH-1:0] pend;
   } exp_t;

   exp_t exp_q[$];

   // Reference state: ratios as plain integers, the number of enabled cycles
   // since the last period boundary, and the output levels.
   int m_a[NUM_CH];
   int m_s[NUM_CH];
   int m_phase[NUM_CH];
   bit m_pend[NUM_CH];
   bit m_div[NUM_CH];
   bit m_tick[NUM_CH];

   always #5 clk = ~clk;

   clk_div_bank #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .CH_W   (CH_W),
      .DEF_DIV(DEF_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .cfg_wr  (cfg_wr),
      .cfg_ch  (cfg_ch),
      .cfg_div (cfg_div),
      .sync    (sync),
      .tick    (tick),
      .div_out (div_out),
      .cfg_pend(cfg_pend)
   );

   // Reference model: one step per rising edge.
   // A channel completes a period after `period` enabled cycles. At that
   // point it ticks, toggles its square wave and adopts any pending ratio.
   always @(posedge clk) begin
      exp_t e;
      int   period;
      bit   hit;
      bit   due;
      if (!model_stop) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
               m_a[i]     = DEF_DIV;
               m_s[i]     = DEF_DIV;
               m_phase[i] = 0;
               m_pend[i]  = 1'b0;
               m_div[i]   = 1'b0;
               m_tick[i]  = 1'b0;
            end else begin
               period = (m_a[i] == 0) ? 1 : m_a[i];
               hit    = cfg_wr && (int'(cfg_ch) == i);
               if (sync) begin
                  m_phase[i] = 0;
                  m_tick[i]  = 1'b0;
                  m_div[i]   = 1'b0;
                  due        = m_pend[i];
               end else if (!en[i]) begin
                  m_phase[i] = 0;
                  m_tick[i]  = 1'b0;
                  due        = m_pend[i];
               end else begin
                  m_phase[i] = m_phase[i] + 1;
                  m_tick[i]  = (m_phase[i] == period);
                  if (m_tick[i]) begin
                     m_phase[i] = 0;
                     m_div[i]   = !m_div[i];
                  end
                  due = m_pend[i] && m_tick[i];
               end
               if (due) begin
                  m_a[i]    = m_s[i];
                  m_pend[i] = 1'b0;
               end
               if (hit) begin
                  m_s[i]    = int'(cfg_div);
                  m_pend[i] = 1'b1;
               end
            end
            e.tick[i] = m_tick[i];
            e.div[i]  = m_div[i];
            e.pend[i] = m_pend[i];
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: compare outputs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (tick !== e.tick) begin
            errors++;
            $display("FAIL tick t=%0t got=%b want=%b", $time, tick, e.tick);
         end
         checks++;
         if (div_out !== e.div) begin
            errors++;
            $display("FAIL div_out t=%0t got=%b want=%b", $time, div_out, e.div);
         end
         checks++;
         if (cfg_pend !== e.pend) begin
            errors++;
            $display("FAIL cfg_pend t=%0t got=%b want=%b", $time, cfg_pend, e.pend);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cfg_wr = 1'b0;
         sync   = 1'b0;
      end
   endtask

   task automatic write_cfg(input int ch, input int d);
      @(negedge clk);
      cfg_wr  = 1'b1;
      sync    = 1'b0;
      cfg_ch  = CH_W'(ch);
      cfg_div = CNT_W'(d);
      $display("cfg write ch=%0d div=%0d t=%0t", ch, d, $time);
   endtask

   task automatic do_sync();
      @(negedge clk);
      cfg_wr = 1'b0;
      sync   = 1'b1;
      $display("sync t=%0t", $time);
   endtask

   initial begin
      // Reset, then release with every channel enabled at the default ratio.
      rst = 1'b1;
      en  = '0;
      repeat (3) @(negedge clk);
      en  = '1;
      rst = 1'b0;
      $display("reset released t=%0t", $time);
      idle(12);

      // Ratio set 1,2,4,8,16, then align all channels with sync.
      write_cfg(0, 1);
      write_cfg(1, 2);
      write_cfg(2, 4);
      write_cfg(3, 8);
      write_cfg(4, 16);
      do_sync();
      idle(70);

      // Mid-count ratio update on channel 0: 5 -> 3.
      write_cfg(0, 5);
      do_sync();
      idle(7);
      write_cfg(0, 3);
      idle(20);

      // Ratios 0 and 1, then a write to a channel index that does not exist.
      write_cfg(1, 0);
      write_cfg(2, 1);
      write_cfg(7, 9);
      do_sync();
      idle(8);

      // Disable channel 2 for three cycles in the middle of a period.
      write_cfg(2, 4);
      do_sync();
      idle(2);
      repeat (3) begin
         @(negedge clk);
         cfg_wr = 1'b0;
         sync   = 1'b0;
         en[2]  = 1'b0;
      end
      @(negedge clk);
      en[2] = 1'b1;
      $display("en[2] restored t=%0t", $time);
      idle(12);

      // Leave a pending write in flight, then pulse reset between clock edges.
      write_cfg(3, 11);
      idle(2);
      @(negedge clk);
      cfg_wr = 1'b0;
      sync   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ((tick !== '0) || (div_out !== '0) || (cfg_pend !== '0)) begin
         errors++;
         $display("FAIL async_reset t=%0t got tick=%b div_out=%b cfg_pend=%b want all 0",
                  $time, tick, div_out, cfg_pend);
      end
      $display("async reset pulse t=%0t", $time);
      @(negedge clk);
      rst = 1'b0;
      idle(10);

      // Randomized traffic.
      repeat (2000) begin
         @(negedge clk);
         for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 15) != 0);
         cfg_wr  = ($urandom_range(0, 3) == 0);
         cfg_ch  = CH_W'($urandom_range(0, 7));
         cfg_div = CNT_W'($urandom_range(0, 12));
         sync    = ($urandom_range(0, 40) == 0);
         if (cfg_wr) $display("rand cfg write ch=%0d div=%0d sync=%0b t=%0t",
                              cfg_ch, cfg_div, sync, $time);
      end

      // Drain the scoreboard and report.
      @(negedge clk);
      cfg_wr     = 1'b0;
      sync       = 1'b0;
      model_stop = 1'b1;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
